// File: rtl/sweep_response_capture.sv
// Sweeps a stimulus from START to LAST in STEP increments, samples the block
// response after SETTLE cycles and queues (stimulus, response) pairs in a show-ahead FIFO.
module sweep_response_capture #(
    parameter int WIDTH  = 8,
    parameter int START  = 0,
    parameter int STEP   = 10,
    parameter int LAST   = 100,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] stim_out,
    input  logic [WIDTH-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_stim,
    output logic [WIDTH-1:0] rd_resp
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0]    CNT_INIT = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] START_V  = WIDTH'(START);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LAST_EXT = (WIDTH+1)'(LAST);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] stim_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH:0]   next_sum;
    logic             push;
    logic             pop;
    logic             full;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        level;

    // One extra bit so the end-of-sweep test never sees a wrapped sum.
    assign next_sum = {1'b0, stim_out} + STEP_EXT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            stim_out <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_d;
            stim_out <= stim_d;
            cnt      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        stim_d  = stim_out;
        cnt_d   = cnt;
        push    = 1'b0;
        busy    = (state != ST_IDLE);
        done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    stim_d  = START_V;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            ST_CAPTURE: begin
                if (!full) begin
                    push = 1'b1;
                    if (next_sum > LAST_EXT) begin
                        state_d = ST_DONE;
                    end else begin
                        stim_d  = next_sum[WIDTH-1:0];
                        cnt_d   = CNT_INIT;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Push looks only at the registered level, so a pop cannot free a slot in the same cycle.
    assign full     = (level == FULL_LVL);
    assign rd_valid = (level != '0);
    assign pop      = rd_valid && rd_ready;
    assign rd_stim  = mem[rd_ptr][2*WIDTH-1:WIDTH];
    assign rd_resp  = mem[rd_ptr][WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {stim_out, resp_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_response_capture.sv
// Randomized bench for sweep_response_capture: a default instance plus a near-top-of-range
// instance and a SETTLE=3 instance, all checked against lists built from the sweep rules.
module tb_sweep_response_capture;

    localparam int START0  = 0;
    localparam int STEP0   = 10;
    localparam int LAST0   = 100;
    localparam int SETTLE0 = 1;
    localparam int DEPTH0  = 4;
    localparam int NENT0   = (LAST0 - START0) / STEP0 + 1;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   rdy_mode = 1;  // 0: hold off, 1: always ready, 2: random

    // default instance
    logic       start0, busy0, done0, valid0, ready0;
    logic [7:0] stim0, resp0, rstim0, rresp0, d0, off0;
    logic [15:0] exp0 [$];

    // START=250, LAST=255 instance
    logic       start_hi, busy_hi, done_hi, valid_hi, ready_hi;
    logic [7:0] stim_hi, resp_hi, rstim_hi, rresp_hi;
    logic [15:0] hi_got [$];

    // SETTLE=3 instance, response only correct three cycles after a stimulus change
    logic       start3, busy3, done3, valid3, ready3;
    logic [7:0] stim3, resp3, rstim3, rresp3, d3a, d3b, d3c;
    logic [15:0] s3_got [$];

    sweep_response_capture u_dut (
        .clk(clk), .rst(rst), .start(start0), .stim_out(stim0), .resp_in(resp0),
        .busy(busy0), .done(done0), .rd_valid(valid0), .rd_ready(ready0),
        .rd_stim(rstim0), .rd_resp(rresp0)
    );

    sweep_response_capture #(.START(250), .STEP(10), .LAST(255)) u_dut_hi (
        .clk(clk), .rst(rst), .start(start_hi), .stim_out(stim_hi), .resp_in(resp_hi),
        .busy(busy_hi), .done(done_hi), .rd_valid(valid_hi), .rd_ready(ready_hi),
        .rd_stim(rstim_hi), .rd_resp(rresp_hi)
    );

    sweep_response_capture #(.START(5), .STEP(7), .LAST(40), .SETTLE(3)) u_dut_s3 (
        .clk(clk), .rst(rst), .start(start3), .stim_out(stim3), .resp_in(resp3),
        .busy(busy3), .done(done3), .rd_valid(valid3), .rd_ready(ready3),
        .rd_stim(rstim3), .rd_resp(rresp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block-under-test models: one register of latency for the default instance, three for SETTLE=3.
    always @(posedge clk) begin
        d0  <= stim0;
        d3a <= stim3;
        d3b <= d3a;
        d3c <= d3b;
    end
    assign resp0   = d0 + off0;
    assign resp_hi = stim_hi + 8'd1;
    assign resp3   = d3c ^ 8'h5A;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reader side: choose rd_ready, then score any handshake that the next edge will complete.
    initial begin
        ready0   = 1'b1;
        ready_hi = 1'b1;
        ready3   = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       ready0 = 1'b0;
                1:       ready0 = 1'b1;
                default: ready0 = 1'($urandom_range(0, 1));
            endcase
            if (valid0 && ready0) begin
                if (exp0.size() == 0) begin
                    check("extra_entry", {rstim0, rresp0}, -1);
                end else begin
                    logic [15:0] e;
                    e = exp0.pop_front();
                    check("rd_stim", rstim0, e[15:8]);
                    check("rd_resp", rresp0, e[7:0]);
                end
            end
            if (valid_hi) hi_got.push_back({rstim_hi, rresp_hi});
            if (valid3)   s3_got.push_back({rstim3, rresp3});
        end
    end

    task automatic sweep0(input int mode, input bit pokes, input bit stall);
        int cyc;
        int dn;
        int n;
        @(negedge clk);
        rdy_mode = stall ? 0 : mode;
        off0 = 8'($urandom);
        for (int v = START0; v <= LAST0; v += STEP0) begin
            exp0.push_back({8'(v), 8'(v + int'(off0))});
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        dn  = 0;
        if (stall) begin
            repeat (20) begin
                cyc++;
                if (done0) dn++;
                @(negedge clk);
            end
            check("stall_stim", stim0, START0 + DEPTH0 * STEP0);
            check("stall_busy", busy0, 1);
            check("stall_valid", valid0, 1);
            check("stall_kept", exp0.size(), NENT0);
            rdy_mode = mode;
        end
        while (busy0 && cyc < 1000) begin
            cyc++;
            if (done0) dn++;
            if (pokes) start0 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start0 = 1'b0;
        if (mode == 1 && !stall) check("busy_len", cyc, NENT0 * (SETTLE0 + 1) + 1);
        check("done_pulses", dn, 1);
        check("hold_last", stim0, LAST0 - (LAST0 - START0) % STEP0);
        repeat (2) @(negedge clk);
        check("no_retrigger", busy0, 0);
        n = 0;
        while (exp0.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drained", exp0.size(), 0);
        repeat (2) @(negedge clk);
        check("fifo_empty", valid0, 0);
    endtask

    initial begin
        int cyc;
        int dn;
        int idx;
        rst      = 1'b0;
        start0   = 1'b0;
        start_hi = 1'b0;
        start3   = 1'b0;
        off0     = 8'd1;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_stim", stim0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_valid", valid0, 0);
        @(negedge clk);
        rst = 1'b0;

        sweep0(1, 1'b0, 1'b0);
        sweep0(1, 1'b1, 1'b0);
        sweep0(1, 1'b0, 1'b1);

        // single entry near the top of the range
        @(negedge clk);
        start_hi = 1'b1;
        @(negedge clk);
        start_hi = 1'b0;
        cyc = 0;
        dn  = 0;
        while (busy_hi && cyc < 100) begin
            cyc++;
            if (done_hi) dn++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        idx = 0;
        for (int v = 250; v <= 255; v += 10) begin
            if (idx < hi_got.size()) begin
                check("hi_stim", hi_got[idx][15:8], v);
                check("hi_resp", hi_got[idx][7:0], (v + 1) % 256);
            end
            idx++;
        end
        check("hi_count", hi_got.size(), idx);
        check("hi_busy_len", cyc, idx * 2 + 1);
        check("hi_done", dn, 1);
        check("hi_hold", stim_hi, 250);

        // SETTLE=3 sweep
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 0;
        dn  = 0;
        while (busy3 && cyc < 200) begin
            cyc++;
            if (done3) dn++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        idx = 0;
        for (int v = 5; v <= 40; v += 7) begin
            if (idx < s3_got.size()) begin
                check("s3_stim", s3_got[idx][15:8], v);
                check("s3_resp", s3_got[idx][7:0], v ^ 'h5A);
            end
            idx++;
        end
        check("s3_count", s3_got.size(), idx);
        check("s3_busy_len", cyc, idx * 4 + 1);
        check("s3_done", dn, 1);

        // asynchronous reset after three pushes
        @(negedge clk);
        rdy_mode = 0;
        off0 = 8'($urandom);
        for (int v = START0; v <= LAST0; v += STEP0) begin
            exp0.push_back({8'(v), 8'(v + int'(off0))});
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_stim", stim0, START0 + 3 * STEP0);
        check("pre_rst_valid", valid0, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_stim", stim0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_valid", valid0, 0);
        @(negedge clk);
        exp0.delete();
        rst = 1'b0;
        rdy_mode = 1;
        sweep0(1, 1'b0, 1'b0);

        repeat (3) sweep0(2, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
